// File: rtl/unsigned_mul.sv
// rtl/unsigned_mul.sv - sequential unsigned shift-add multiplier with start/ready handshake
// Optional feature macro: MUL_EARLY_EXIT_EN (finish as soon as the remaining multiplier bits are zero)

module unsigned_mul #(
    parameter int N = 16,
    parameter int M = 16,
    parameter int L = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     word1,
    input  logic [M-1:0]     word2,
    output logic [N+M-1:0]   product,
    output logic             ready
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]   mreg;
    logic [N+M-1:0] sreg;
    logic [N+M-1:0] acc;
    logic [L-1:0]   cnt;

    logic           load;
    logic           last_iter;

    // The final iteration is either the N-th bit, or (early exit) the point where
    // no set multiplier bits remain above the one being consumed now.
`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (cnt == L'(N - 1)) || (mreg[N-1:1] == '0);
`else
    assign last_iter = (cnt == L'(N - 1));
`endif

    // Controller state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Controller next-state and load strobe; start is only honoured while idle
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture on load, then one multiplier bit per clock while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mreg <= '0;
            sreg <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (load) begin
            mreg <= word1;
            sreg <= {{N{1'b0}}, word2};
            acc  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            if (mreg[0]) begin
                acc <= acc + sreg;
            end
            sreg <= sreg << 1;
            mreg <= mreg >> 1;
            cnt  <= cnt + L'(1);
        end
    end

    // acc is untouched while idle, so it doubles as the held result
    assign product = acc;
    assign ready   = (state == IDLE);

endmodule
